// File: rtl/pix_capture_buf.sv
// Triggered pixel capture buffer: records one selected channel per capture. PIX_CAPTURE_PRETRIG_EN adds circular pre-trigger history.
// Readout latency is 2 cycles and fully pipelined. There is no backpressure: din is taken whenever din_valid is high.
module pix_capture_buf #(
  parameter  int DWIDTH  = 32,
  parameter  int AWIDTH  = 10,
  parameter  int NCHAN   = 4,
  parameter  int PRETRIG = 256,
  localparam int CSEL_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCHAN*DWIDTH-1:0] din,
  input  logic                    din_valid,
  input  logic [CSEL_W-1:0]       chan_sel,
  input  logic                    arm,
  input  logic                    trig,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [AWIDTH:0]         wr_count,
  output logic [AWIDTH-1:0]       trig_addr,
  input  logic                    rd_en,
  input  logic [AWIDTH-1:0]       rd_addr,
  output logic [DWIDTH-1:0]       rd_data,
  output logic                    rd_valid
);

`ifdef PIX_CAPTURE_PRETRIG_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] PRE_C   = PRETRIG[AWIDTH:0];
  // Writes from the trigger cycle (inclusive) until the capture is complete.
  localparam logic [AWIDTH:0] POST_N  = PRE_EN ? (DEPTH_C - PRE_C) : DEPTH_C;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t              state;
  logic [CSEL_W-1:0]   chan_q;
  logic [AWIDTH-1:0]   wr_ptr;
  logic [AWIDTH:0]     post_cnt;
  logic [DWIDTH-1:0]   mem [0:DEPTH-1];
  logic [DWIDTH-1:0]   rd_prim;
  logic                rd_v1;

  logic                trig_ok;
  logic                post_wr;
  logic                wr_en;
  logic                last_wr;
  logic [DWIDTH-1:0]   wr_dat;

  // Pre-trigger gating only bites when history capture is enabled.
  assign trig_ok = (state == ARMED) && trig && (!PRE_EN || (wr_count >= PRE_C));
  assign post_wr = !abort && din_valid && ((state == CAPTURE) || trig_ok);
  assign wr_en   = post_wr || (!abort && din_valid && (state == ARMED) && PRE_EN);
  assign last_wr = post_wr && ((post_cnt + 1'b1) == POST_N);
  assign wr_dat  = din[int'(chan_q)*DWIDTH +: DWIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
      trig_addr <= '0;
      wr_ptr    <= '0;
      chan_q    <= '0;
      post_cnt  <= '0;
    end else if (abort) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_count != DEPTH_C) wr_count <= wr_count + 1'b1;
      end
      if (post_wr) post_cnt <= post_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state     <= ARMED;
            busy      <= 1'b1;
            done      <= 1'b0;
            chan_q    <= chan_sel;
            wr_count  <= '0;
            trig_addr <= '0;
            wr_ptr    <= '0;
            post_cnt  <= '0;
          end
        end
        ARMED: begin
          if (trig_ok) begin
            trig_addr <= wr_ptr;
            if (last_wr) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (last_wr) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-first RAM: the registered read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
    if (rd_en) rd_prim <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_v1    <= rd_en;
      rd_valid <= rd_v1;
      if (rd_v1) rd_data <= rd_prim;
    end
  end

endmodule

// File: tb/tb_pix_capture_buf.sv
// Scoreboarded bench for pix_capture_buf: stimulus pushes expected readback, a negedge monitor pops and compares.
module tb_pix_capture_buf;
  localparam int DW = 32, AW = 4, NC = 4, PT = 4, DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC*DW-1:0]  din = '0;
  logic              din_valid = 1'b0;
  logic [1:0]        chan_sel = '0;
  logic              arm = 1'b0, trig = 1'b0, abort = 1'b0;
  logic              busy, done;
  logic [AW:0]       wr_count;
  logic [AW-1:0]     trig_addr;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;

  pix_capture_buf #(.DWIDTH(DW), .AWIDTH(AW), .NCHAN(NC), .PRETRIG(PT)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .chan_sel(chan_sel),
    .arm(arm), .trig(trig), .abort(abort), .busy(busy), .done(done),
    .wr_count(wr_count), .trig_addr(trig_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] dat; int due; } rd_exp_t;
  rd_exp_t     exp_q[$];
  logic [31:0] mdl [DEPTH];
  int          nvec = 0, nerr = 0;
  int          sel_drv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic b, input logic d, input int wc);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".wr_count"}, {27'd0, wr_count}, wc);
  endtask

  // One clock of stimulus; the model's channel carries d, the others noise.
  task automatic cyc_in(input logic v, input logic [31:0] d, input logic a, input logic t, input logic ab);
    din_valid = v; arm = a; trig = t; abort = ab;
    for (int k = 0; k < NC; k++) din[k*DW +: DW] = (k == sel_drv) ? d : $urandom();
    @(posedge clk); #1;
    din_valid = 1'b0; arm = 1'b0; trig = 1'b0; abort = 1'b0;
  endtask

  task automatic send_valid(input logic [31:0] d, input logic a, input logic t, input logic ab);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) cyc_in(1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
    cyc_in(1'b1, d, a, t, ab);
  endtask

  task automatic rd(input int a);
    rd_exp_t e;
    e.dat = mdl[a % DEPTH];
    e.due = cyc + 2;
    exp_q.push_back(e);
    rd_en = 1'b1; rd_addr = 4'(a);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      nvec++; nerr++;
      $display("FAIL rd_drain: %0d reads outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL rd_unexpected: rd_valid=1 data=0x%0h, required no read", rd_data);
      end else begin
        e = exp_q.pop_front();
        nvec++;
        if (rd_data !== e.dat || cyc != e.due) begin
          nerr++;
          $display("FAIL rd_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d", rd_data, cyc, e.dat, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      nvec++; nerr++;
      $display("FAIL rd_missing: rd_valid=0 at cycle %0d, required 0x%0h", cyc, e.dat);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_st("reset", 1'b0, 1'b0, 0);
    chk("reset.trig_addr", {28'd0, trig_addr}, 32'd0);
    chk("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset.rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    cyc_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

`ifndef PIX_CAPTURE_PRETRIG_EN
    // Basic capture on channel 2; chan_sel is scrambled after arm.
    sel_drv = 2; chan_sel = 2'd2;
    cyc_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chan_sel = 2'($urandom());
    chk_st("armed", 1'b1, 1'b0, 0);
    cyc_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("trig.trig_addr", {28'd0, trig_addr}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      send_valid(32'h100 + i, 1'b0, 1'b0, 1'b0);
      mdl[i] = 32'h100 + i;
      if (i == 14) chk_st("basic.s15", 1'b1, 1'b0, 15);
    end
    chk_st("basic.done", 1'b0, 1'b1, 16);
    for (int i = 0; i < 16; i++) rd(i ^ 5);
    drain();

    // Abort on the 5th capture sample, then a clean capture on channel 3.
    sel_drv = 1; chan_sel = 2'd1;
    cyc_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_valid(32'h500 + i, 1'b0, 1'b0, 1'b0);
    chk_st("abort.pre", 1'b1, 1'b0, 4);
    send_valid(32'h504, 1'b0, 1'b0, 1'b1);
    chk_st("abort.post", 1'b0, 1'b0, 0);
    sel_drv = 3; chan_sel = 2'd3;
    cyc_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chan_sel = 2'd0;
    cyc_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_valid(32'h200 + i, (i == 5), (i == 9), 1'b0);
      mdl[i] = 32'h200 + i;
    end
    chk_st("recap.done", 1'b0, 1'b1, 16);
    cyc_in(1'b1, 32'hdead_beef, 1'b0, 1'b1, 1'b0);
    chk_st("done.trig_ignored", 1'b0, 1'b1, 16);
    rd(0); rd(1); rd(7); rd(15);
    drain();

    // Same-cycle arm and trig from IDLE: arm only, no write until a later trig.
    cyc_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk_st("idle", 1'b0, 1'b0, 0);
    sel_drv = 0; chan_sel = 2'd0;
    cyc_in(1'b1, 32'hbad0_0001, 1'b1, 1'b1, 1'b0);
    chk_st("armtrig", 1'b1, 1'b0, 0);
    cyc_in(1'b1, 32'hbad0_0002, 1'b0, 1'b0, 1'b0);
    cyc_in(1'b1, 32'hbad0_0003, 1'b0, 1'b0, 1'b0);
    chk_st("armed.nowrite", 1'b1, 1'b0, 0);
    cyc_in(1'b1, 32'h3a5, 1'b0, 1'b1, 1'b0);
    mdl[0] = 32'h3a5;
    chk_st("late_trig", 1'b1, 1'b0, 1);
    cyc_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    rd(0); rd(1);
    drain();

    // Asynchronous reset after 7 samples; memory must survive.
    cyc_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send_valid(32'h400 + i, 1'b0, 1'b0, 1'b0);
      mdl[i] = 32'h400 + i;
    end
    chk_st("rst.pre", 1'b1, 1'b0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk_st("rst.async", 1'b0, 1'b0, 0);
    chk("rst.trig_addr", {28'd0, trig_addr}, 32'd0);
    chk("rst.rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst.rd_data", rd_data, 32'd0);
    repeat (3) cyc_in(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) rd(i);
    drain();
`else
    begin : pretrig
      int stored, post, trig_idx;
      logic t;
      logic [31:0] exp_ta;
      stored = 0; post = 0; trig_idx = -1; exp_ta = 0;
      sel_drv = 2; chan_sel = 2'd2;
      cyc_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chan_sel = 2'($urandom());
      for (int i = 0; i < 64; i++) begin
        t = ((i >= 1 && i <= 3) || i == 10);
        if (trig_idx < 0 && t && stored >= PT) begin
          trig_idx = i;
          exp_ta = stored % DEPTH;
        end
        send_valid(32'h600 + i, 1'b0, t, 1'b0);
        mdl[stored % DEPTH] = 32'h600 + i;
        stored++;
        if (trig_idx >= 0) post++;
        chk_st("pre.sample", (post != DEPTH - PT), (post == DEPTH - PT), (stored > DEPTH) ? DEPTH : stored);
        if (post == DEPTH - PT) break;
      end
      if (post != DEPTH - PT) begin
        nvec++; nerr++;
        $display("FAIL pre.timeout: %0d post-trigger writes, required %0d", post, DEPTH - PT);
      end
      chk("pre.trig_addr", {28'd0, trig_addr}, exp_ta);
      for (int j = 0; j < DEPTH; j++) rd((int'(exp_ta) - PT + DEPTH + j) % DEPTH);
      drain();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
